// File: rtl/qm_imem_resp.sv
// rtl/qm_imem_resp.sv - icache line-fill responder: fixed latency, critical-word-first wrapping burst
// Backdoor load port writes storage in any state; reads are read-before-write.
module qm_imem_resp #(
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    output logic                          resp_valid,
    output logic [31:0]                   resp_data,
    output logic [$clog2(LINE_WORDS)-1:0] resp_index,
    output logic                          resp_last,
    output logic                          resp_error,
    output logic                          busy,
    input  logic                          load_we,
    input  logic [31:0]                   load_addr,
    input  logic [31:0]                   load_data
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);
    localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [AW-IW-1:0] r_line;
    logic [IW-1:0]    r_off;
    logic [IW-1:0]    r_beat;
    logic             r_err;
    logic [31:0]      r_mem [MEM_WORDS];

    logic [29:0]   w_req_word;
    logic [29:0]   w_load_word;
    logic          w_accept;
    logic          w_load_ok;
    logic          w_present;
    logic [AW-1:0] w_rd_addr;
    logic          w_unused;

    assign w_req_word  = req_addr[31:2];
    assign w_load_word = load_addr[31:2];
    assign w_accept    = req_valid && req_ready && (r_state == S_IDLE);
    assign w_load_ok   = load_we && (w_load_word < 30'(MEM_WORDS));
    assign w_rd_addr   = {r_line, r_off};
    assign w_unused    = ^{req_addr[1:0], load_addr[1:0]};

    // A beat is presented on the edge that leaves WAIT and on every BURST edge until the last one.
    assign w_present = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                       ((r_state == S_BURST) && !resp_last);

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[w_load_word[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_line     <= '0;
            r_off      <= '0;
            r_beat     <= '0;
            r_err      <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_index <= '0;
            resp_last  <= 1'b0;
            resp_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_cnt     <= CNT_INIT;
                        r_line    <= w_req_word[AW-1:IW];
                        r_off     <= w_req_word[IW-1:0];
                        r_beat    <= '0;
                        r_err     <= (w_req_word >= 30'(MEM_WORDS));
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_BURST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_BURST: begin
                    if (resp_last) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_last  <= 1'b0;
                        resp_error <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_present) begin
                resp_valid <= 1'b1;
                resp_index <= r_off;
                resp_data  <= r_err ? 32'h0 : r_mem[w_rd_addr];
                resp_error <= r_err;
                resp_last  <= (r_beat == LAST_BEAT);
                r_off      <= r_off + 1'b1;
                r_beat     <= r_beat + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qm_imem_resp.sv
// tb/tb_qm_imem_resp.sv - directed bench for qm_imem_resp with default parameters
module tb_qm_imem_resp;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_index;
    logic        resp_last;
    logic        resp_error;
    logic        busy;

    qm_imem_resp dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_index(resp_index),
        .resp_last (resp_last),
        .resp_error(resp_error),
        .busy      (busy),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] a_word [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    localparam logic [31:0] NEW_A3 = 32'h5EED_F00D;

    int          cap_n;
    int          cap_busy;
    int          cap_ready;
    int          cap_cyc  [8];
    logic [31:0] cap_data [8];
    logic [1:0]  cap_idx  [8];
    logic        cap_last [8];
    logic        cap_err  [8];

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_we = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // Returns just after the accepting edge; cycle 0 is the following negedge.
    task automatic do_accept(input logic [31:0] a, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
        else pass_cnt++;
        req_valid = 1'b1;
        req_addr = a;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic capture(input int ncyc);
        cap_n = 0;
        cap_busy = 0;
        cap_ready = -1;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (resp_valid && cap_n < 8) begin
                cap_cyc[cap_n]  = n;
                cap_data[cap_n] = resp_data;
                cap_idx[cap_n]  = resp_index;
                cap_last[cap_n] = resp_last;
                cap_err[cap_n]  = resp_error;
                cap_n++;
            end
            if (busy) cap_busy++;
            if (req_ready && cap_ready < 0) cap_ready = n;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({req_ready, resp_valid, resp_last, resp_error, busy} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000", {req_ready, resp_valid, resp_last, resp_error, busy});
        else pass_cnt++;
        total_cnt++;
        if ({resp_data, resp_index} !== 34'h0)
            $display("FAIL reset_data: got %h required 0", {resp_data, resp_index});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_critical_word();
        for (int i = 0; i < 4; i++) load_word(32'h40 + 32'(4 * i), a_word[i]);
        do_accept(32'h48, 1'b0);
        capture(12);
        total_cnt++;
        if (cap_n !== 4) $display("FAIL t1_beats: got %0d required 4", cap_n);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ei = 2'(2 + i);
            total_cnt++;
            if ({cap_cyc[i], cap_idx[i], cap_last[i], cap_err[i], cap_data[i]} !==
                {3 + i, ei, (i == 3), 1'b0, a_word[ei]})
                $display("FAIL t1_beat%0d: got cyc=%0d idx=%0d last=%b err=%b data=%h required cyc=%0d idx=%0d last=%b err=0 data=%h",
                         i, cap_cyc[i], cap_idx[i], cap_last[i], cap_err[i], cap_data[i], 3 + i, ei, (i == 3), a_word[ei]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cap_ready !== 7) $display("FAIL t1_ready_after: got cycle %0d required 7", cap_ready);
        else pass_cnt++;
    endtask

    task automatic test_aligned();
        do_accept(32'h40, 1'b0);
        capture(12);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({cap_idx[i], cap_data[i]} !== {2'(i), a_word[i]})
                $display("FAIL t2_beat%0d: got idx=%0d data=%h required idx=%0d data=%h",
                         i, cap_idx[i], cap_data[i], i, a_word[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cap_busy !== 7) $display("FAIL t2_busy_cycles: got %0d required 7", cap_busy);
        else pass_cnt++;
    endtask

    task automatic test_error();
        do_accept(32'h1000, 1'b0);
        capture(12);
        total_cnt++;
        if (cap_n !== 4) $display("FAIL t3_err_beats: got %0d required 4", cap_n);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({cap_cyc[i], cap_err[i], cap_data[i]} !== {3 + i, 1'b1, 32'h0})
                $display("FAIL t3_err_beat%0d: got cyc=%0d err=%b data=%h required cyc=%0d err=1 data=0",
                         i, cap_cyc[i], cap_err[i], cap_data[i], 3 + i);
            else pass_cnt++;
        end
        do_accept(32'h44, 1'b0);
        capture(12);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ei = 2'(1 + i);
            total_cnt++;
            if ({cap_err[i], cap_idx[i], cap_data[i]} !== {1'b0, ei, a_word[ei]})
                $display("FAIL t3_ok_beat%0d: got err=%b idx=%0d data=%h required err=0 idx=%0d data=%h",
                         i, cap_err[i], cap_idx[i], cap_data[i], ei, a_word[ei]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_valid();
        do_accept(32'h40, 1'b1);
        req_addr = 32'h4C;
        capture(8);
        total_cnt++;
        if (cap_n !== 4) $display("FAIL t4_one_burst: got %0d beats required 4", cap_n);
        else pass_cnt++;
        total_cnt++;
        if ({cap_idx[0], cap_data[0], cap_idx[3], cap_data[3]} !== {2'd0, a_word[0], 2'd3, a_word[3]})
            $display("FAIL t4_first_burst: got idx0=%0d d0=%h idx3=%0d d3=%h required 0 %h 3 %h",
                     cap_idx[0], cap_data[0], cap_idx[3], cap_data[3], a_word[0], a_word[3]);
        else pass_cnt++;
        total_cnt++;
        if (cap_ready !== 7) $display("FAIL t4_ready: got cycle %0d required 7", cap_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        capture(12);
        total_cnt++;
        if ({cap_n, cap_cyc[0], cap_idx[0], cap_data[0], cap_idx[1], cap_data[1]} !==
            {32'd4, 32'd3, 2'd3, a_word[3], 2'd0, a_word[0]})
            $display("FAIL t4_second_burst: got n=%0d cyc=%0d idx=%0d d=%h idx=%0d d=%h required n=4 cyc=3 idx=3 d=%h idx=0 d=%h",
                     cap_n, cap_cyc[0], cap_idx[0], cap_data[0], cap_idx[1], cap_data[1], a_word[3], a_word[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        do_accept(32'h40, 1'b0);
        repeat (6) @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_index, resp_data} !== {1'b1, 2'd2, a_word[2]})
            $display("FAIL t5_beat2: got v=%b idx=%0d d=%h required v=1 idx=2 d=%h",
                     resp_valid, resp_index, resp_data, a_word[2]);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({resp_valid, busy, resp_last, resp_data} !== 35'h0)
            $display("FAIL t5_async_clear: got v=%b busy=%b last=%b d=%h required all 0",
                     resp_valid, busy, resp_last, resp_data);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL t5_ready_in_reset: got %b required 0", req_ready);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL t5_ready_after: got %b required 1", req_ready);
        else pass_cnt++;
        do_accept(32'h40, 1'b0);
        capture(12);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (cap_data[i] !== a_word[i])
                $display("FAIL t5_reread%0d: got %h required %h", i, cap_data[i], a_word[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_collision();
        do_accept(32'h40, 1'b0);
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (n == 5) begin
                load_addr = 32'h4C;
                load_data = NEW_A3;
                load_we = 1'b1;
            end
            if (n == 6) begin
                load_we = 1'b0;
                total_cnt++;
                if ({resp_valid, resp_index, resp_last, resp_data} !== {1'b1, 2'd3, 1'b1, a_word[3]})
                    $display("FAIL t6_old_value: got v=%b idx=%0d last=%b d=%h required v=1 idx=3 last=1 d=%h",
                             resp_valid, resp_index, resp_last, resp_data, a_word[3]);
                else pass_cnt++;
            end
        end
        do_accept(32'h4C, 1'b0);
        capture(12);
        total_cnt++;
        if ({cap_idx[0], cap_data[0], cap_data[1]} !== {2'd3, NEW_A3, a_word[0]})
            $display("FAIL t6_new_value: got idx=%0d d0=%h d1=%h required idx=3 d0=%h d1=%h",
                     cap_idx[0], cap_data[0], cap_data[1], NEW_A3, a_word[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_critical_word();
        test_aligned();
        test_error();
        test_hold_valid();
        test_reset_mid_burst();
        test_load_collision();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
